// File: rtl/if_stage.sv
// ============================================================================
// if_stage -- instruction-fetch stage of the 5-stage MIPS pipeline
// ============================================================================
// Purpose:
//   Owns the fetch PC, issues instruction-memory requests and produces the
//   IF/ID pipeline register (PC1, IR1, PCnext1) consumed by decode. Handles
//   global freeze (NewHalt), load-use stall (Bubble), branch/jump redirect
//   with flush, instruction-memory wait states and a syscall HALT state.
//
// Parameters:
//   RESET_PC   PC loaded on clear.
//   IMEM_AW    instruction-memory word-address width (imem_addr = PC[IMEM_AW+1:2]).
//
// Ports:
//   clk          in   pipeline clock
//   clear        in   synchronous active-high reset
//   NewHalt      in   global advance enable; 0 freezes all state
//   Bubble       in   load-use stall; holds PC and IF/ID
//   redirect     in   taken branch/jump/jr from downstream
//   redirect_pc  in   redirect target (bits [1:0] forced to 0)
//   halt_req     in   syscall-exit pulse; enter HALT
//   resume       in   leave HALT
//   imem_req     out  fetch request valid (RUN/WAIT)
//   imem_addr    out  word address of current PC
//   imem_ready   in   imem_rdata valid for imem_addr this cycle
//   imem_rdata   in   instruction word
//   PC1          out  IF/ID PC
//   IR1          out  IF/ID instruction (0 = bubble, sll $0,$0,0)
//   PCnext1      out  IF/ID PC+4
//   halted       out  1 while in HALT
//   pc_out       out  current fetch PC
//
// Optional build macro IF_STATS_EN:
//   Adds fetch_cnt (instruction loads into IF/ID) and stall_cnt (cycles held
//   by Bubble or by an imem wait), both saturating and frozen by NewHalt=0.
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               NewHalt,
    input  logic               Bubble,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               halt_req,
    input  logic               resume,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        PC1,
    output logic [31:0]        IR1,
    output logic [31:0]        PCnext1,
    output logic               halted,
    output logic [31:0]        pc_out
`ifdef IF_STATS_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    // Saturating increment used by the statistics counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end
        return v + 32'd1;
    endfunction

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_pc_p1;
    logic [31:0] r_ir_p1;
    logic [31:0] r_pcnext_p1;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_tgt;
    logic        w_unused_redirect_lsbs;

    // Mutually exclusive per-edge actions, in priority order.
    logic w_do_redirect;
    logic w_do_halt;
    logic w_do_bubble;
    logic w_do_wait;
    logic w_do_load;

    assign w_pc_plus4             = r_pc + 32'd4;   // wraps modulo 2^32
    assign w_redirect_tgt         = {redirect_pc[31:2], 2'b00};
    assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        w_do_redirect = 1'b0;
        w_do_halt     = 1'b0;
        w_do_bubble   = 1'b0;
        w_do_wait     = 1'b0;
        w_do_load     = 1'b0;
        if (NewHalt) begin
            if (redirect) begin
                w_do_redirect = 1'b1;
            end else if (r_state == S_HALT) begin
                w_do_halt = 1'b1;
            end else if (Bubble) begin
                w_do_bubble = 1'b1;
            end else if (!imem_ready) begin
                w_do_wait = 1'b1;
            end else begin
                w_do_load = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic. A redirect outside HALT restarts the fetch in
    // RUN on the new address; a halt_req coinciding with a redirect is held
    // by downstream and taken on the following advancing cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (NewHalt) begin
            if (redirect) begin
                w_state_nxt = (r_state == S_HALT) ? S_HALT : S_RUN;
            end else if (halt_req) begin
                w_state_nxt = S_HALT;
            end else begin
                case (r_state)
                    S_RUN:   if (!imem_ready) w_state_nxt = S_WAIT;
                    S_WAIT:  if (imem_ready)  w_state_nxt = S_RUN;
                    S_HALT:  if (resume)      w_state_nxt = S_RUN;
                    default: w_state_nxt = S_RUN;
                endcase
            end
        end
    end

    // FSM: outputs decoded from the state register only.
    always_comb begin
        imem_req = 1'b1;
        halted   = 1'b0;
        if (r_state == S_HALT) begin
            imem_req = 1'b0;
            halted   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Fetch PC
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            r_pc <= RESET_PC;
        end else if (w_do_redirect) begin
            r_pc <= w_redirect_tgt;
        end else if (w_do_load) begin
            r_pc <= w_pc_plus4;
        end
    end

    assign pc_out    = r_pc;
    assign imem_addr = r_pc[IMEM_AW+1:2];

    // ------------------------------------------------------------------
    // IF/ID pipeline register (stage 1)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            r_pc_p1     <= 32'd0;
            r_ir_p1     <= 32'd0;
            r_pcnext_p1 <= 32'd0;
        end else if (w_do_redirect || w_do_halt || w_do_wait) begin
            r_pc_p1     <= 32'd0;
            r_ir_p1     <= 32'd0;
            r_pcnext_p1 <= 32'd0;
        end else if (w_do_load) begin
            r_pc_p1     <= r_pc;
            r_ir_p1     <= imem_rdata;
            r_pcnext_p1 <= w_pc_plus4;
        end
    end

    assign PC1     = r_pc_p1;
    assign IR1     = r_ir_p1;
    assign PCnext1 = r_pcnext_p1;

`ifdef IF_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters
    // ------------------------------------------------------------------
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (w_do_load) begin
                r_fetch_cnt <= sat_inc(r_fetch_cnt);
            end
            if (w_do_bubble || w_do_wait) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: hand-computed vectors for fetch, imem
// wait, Bubble hold, redirect flush, HALT/resume, NewHalt freeze, PC wrap and
// clear from WAIT/HALT.
module tb_if_stage;

    logic        clk;
    logic        clear;
    logic        NewHalt;
    logic        Bubble;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        resume;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PC1;
    logic [31:0] IR1;
    logic [31:0] PCnext1;
    logic        halted;
    logic [31:0] pc_out;
`ifdef IF_STATS_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    if_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
        .clk         (clk),
        .clear       (clear),
        .NewHalt     (NewHalt),
        .Bubble      (Bubble),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .resume      (resume),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .PC1         (PC1),
        .IR1         (IR1),
        .PCnext1     (PCnext1),
        .halted      (halted),
        .pc_out      (pc_out)
`ifdef IF_STATS_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc1,
                              input logic [31:0] ir1, input logic [31:0] pcn1);
        check({tag, ".PC1"}, PC1, pc1);
        check({tag, ".IR1"}, IR1, ir1);
        check({tag, ".PCnext1"}, PCnext1, pcn1);
    endtask

    initial begin
        clear = 1'b1; NewHalt = 1'b1; Bubble = 1'b0; redirect = 1'b0;
        redirect_pc = 32'd0; halt_req = 1'b0; resume = 1'b0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        tick(); tick();

        // Reset state
        check_ifid("rst", 32'd0, 32'd0, 32'd0);
        check("rst.pc", pc_out, 32'd0);
        check("rst.halted", {31'd0, halted}, 32'd0);
        check("rst.req", {31'd0, imem_req}, 32'd1);

        // Three back-to-back fetches
        clear = 1'b0;
        imem_ready = 1'b1;
        check("f0.addr", {22'd0, imem_addr}, 32'd0);
        imem_rdata = 32'h2008_0001; tick();
        check_ifid("f0", 32'h0, 32'h2008_0001, 32'h4);
        imem_rdata = 32'h2009_0002; tick();
        check_ifid("f1", 32'h4, 32'h2009_0002, 32'h8);
        imem_rdata = 32'h0109_5020; tick();
        check_ifid("f2", 32'h8, 32'h0109_5020, 32'hC);
        check("f2.pc", pc_out, 32'hC);
        check("f2.addr", {22'd0, imem_addr}, 32'd3);
        imem_rdata = 32'h1111_1111; tick();
        check("f3.pc", pc_out, 32'h10);

        // Two imem wait cycles at PC=0x10
        imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF; tick();
        check_ifid("w0", 32'h0, 32'h0, 32'h0);
        check("w0.pc", pc_out, 32'h10);
        tick();
        check("w1.IR1", IR1, 32'h0);
        check("w1.pc", pc_out, 32'h10);
        check("w1.addr", {22'd0, imem_addr}, 32'd4);
        check("w1.req", {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1; imem_rdata = 32'h8D09_0000; tick();
        check_ifid("w2", 32'h10, 32'h8D09_0000, 32'h14);
        check("w2.pc", pc_out, 32'h14);

        // Bubble holds PC and IF/ID, with and without imem_ready
        Bubble = 1'b1; imem_ready = 1'b0; tick();
        check_ifid("b0", 32'h10, 32'h8D09_0000, 32'h14);
        check("b0.pc", pc_out, 32'h14);
        imem_ready = 1'b1; imem_rdata = 32'h1234_5678; tick();
        check("b1.IR1", IR1, 32'h8D09_0000);
        check("b1.pc", pc_out, 32'h14);

        // Redirect wins over Bubble and imem wait; low bits dropped
        redirect = 1'b1; redirect_pc = 32'h0000_0043; imem_ready = 1'b0; tick();
        check_ifid("rd", 32'h0, 32'h0, 32'h0);
        check("rd.pc", pc_out, 32'h40);
        redirect = 1'b0; Bubble = 1'b0;
        imem_ready = 1'b1; imem_rdata = 32'hAAAA_0001; tick();
        check_ifid("rd1", 32'h40, 32'hAAAA_0001, 32'h44);
        check("rd1.pc", pc_out, 32'h44);

        // NewHalt=0 freezes everything; halt_req ignored
        NewHalt = 1'b0; halt_req = 1'b1; imem_rdata = 32'h5555_5555; tick(); tick();
        check("nh.IR1", IR1, 32'hAAAA_0001);
        check("nh.pc", pc_out, 32'h44);
        check("nh.halted", {31'd0, halted}, 32'd0);
        halt_req = 1'b0; NewHalt = 1'b1;

        // halt_req: this edge still loads, HALT entered next
        halt_req = 1'b1; imem_rdata = 32'hBBBB_0002; tick();
        check_ifid("h0", 32'h44, 32'hBBBB_0002, 32'h48);
        check("h0.halted", {31'd0, halted}, 32'd1);
        check("h0.req", {31'd0, imem_req}, 32'd0);
        halt_req = 1'b0; tick();
        check_ifid("h1", 32'h0, 32'h0, 32'h0);
        check("h1.pc", pc_out, 32'h48);
        check("h1.halted", {31'd0, halted}, 32'd1);

        // Redirect in HALT updates PC only
        redirect = 1'b1; redirect_pc = 32'h0000_0100; tick();
        redirect = 1'b0;
        check("h2.pc", pc_out, 32'h100);
        check("h2.halted", {31'd0, halted}, 32'd1);

        // halt_req + resume together: stay halted
        halt_req = 1'b1; resume = 1'b1; tick();
        check("h3.halted", {31'd0, halted}, 32'd1);
        halt_req = 1'b0; tick();
        resume = 1'b0;
        check("h4.halted", {31'd0, halted}, 32'd0);
        check("h4.req", {31'd0, imem_req}, 32'd1);
        check("h4.IR1", IR1, 32'h0);
        check("h4.pc", pc_out, 32'h100);
        imem_rdata = 32'hCCCC_0003; tick();
        check_ifid("h5", 32'h100, 32'hCCCC_0003, 32'h104);
        check("h5.pc", pc_out, 32'h104);

        // clear in the middle of WAIT
        redirect = 1'b1; redirect_pc = 32'h0000_0200; tick();
        redirect = 1'b0; imem_ready = 1'b0; tick();
        check("cw.pc", pc_out, 32'h200);
        clear = 1'b1; tick();
        clear = 1'b0;
        check("cw.pc0", pc_out, 32'h0);
        check("cw.IR1", IR1, 32'h0);

        // clear in the middle of HALT
        halt_req = 1'b1; tick();
        halt_req = 1'b0;
        check("ch.halted", {31'd0, halted}, 32'd1);
        clear = 1'b1; tick();
        clear = 1'b0;
        check("ch.halted0", {31'd0, halted}, 32'd0);
        check("ch.req", {31'd0, imem_req}, 32'd1);

        // PC wrap at 0xFFFF_FFFC (fresh counters after clear)
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; tick();
        redirect = 1'b0;
        check("wr.pc", pc_out, 32'hFFFF_FFFC);
        imem_ready = 1'b1; imem_rdata = 32'hDDDD_0004; tick();
        check_ifid("wr", 32'hFFFF_FFFC, 32'hDDDD_0004, 32'h0);
        check("wr.pc0", pc_out, 32'h0);
`ifdef IF_STATS_EN
        check("st.fetch", fetch_cnt, 32'd1);
        check("st.stall0", stall_cnt, 32'd0);
        imem_ready = 1'b0; tick();
        check("st.stall1", stall_cnt, 32'd1);
        Bubble = 1'b1; tick();
        Bubble = 1'b0;
        check("st.stall2", stall_cnt, 32'd2);
        check("st.fetch1", fetch_cnt, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
